// File: rtl/hex_print_ctrl.sv
// Two-requester round-robin hex printer: captures one word per grant and streams it
// MSB-nibble-first as uppercase ASCII characters, optionally followed by a separator.
module hex_print_ctrl #(
    parameter int unsigned DIGITS = 4,
    parameter bit          SEP_EN = 1'b1,
    parameter logic [7:0]  SEP    = 8'h20,
    localparam int unsigned W     = 4 * DIGITS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_data,
    output logic         req1_ready,
    output logic         char_valid,
    output logic [7:0]   char_data,
    input  logic         char_ready,
    output logic         busy,
    output logic         grant_id
);

    localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, DIGIT, SEPC} state_t;

    state_t           r_state, w_state_nxt;
    logic [W-1:0]     r_word, w_word_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_grant_id, w_grant_id_nxt;
    logic             r_last_grant, w_last_grant_nxt;

    logic             w_idle;
    logic             w_winner;
    logic             w_accept;
    logic             w_char_hs;
    logic [W-1:0]     w_shifted;
    logic [3:0]       w_nib;

    assign w_idle = (r_state == IDLE);

    // Round-robin only matters on a tie; a lone requester always wins.
    always_comb begin
        if (req0_valid && req1_valid) begin
            w_winner = ~r_last_grant;
        end else begin
            w_winner = req1_valid;
        end
    end

    assign req0_ready = w_idle & req0_valid & ~w_winner;
    assign req1_ready = w_idle & req1_valid & w_winner;
    assign w_accept   = req0_ready | req1_ready;

    assign w_shifted = r_word >> {r_cnt, 2'b00};
    assign w_nib     = w_shifted[3:0];

    always_comb begin
        char_data = 8'h00;
        unique case (r_state)
            DIGIT:   char_data = {4'h0, w_nib} + ((w_nib < 4'd10) ? 8'h30 : 8'h37);
            SEPC:    char_data = SEP;
            default: char_data = 8'h00;
        endcase
    end

    assign char_valid = ~w_idle;
    assign w_char_hs  = char_valid & char_ready;
    assign busy       = ~w_idle;
    assign grant_id   = r_grant_id;

    always_comb begin
        w_state_nxt      = r_state;
        w_word_nxt       = r_word;
        w_cnt_nxt        = r_cnt;
        w_grant_id_nxt   = r_grant_id;
        w_last_grant_nxt = r_last_grant;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_word_nxt       = w_winner ? req1_data : req0_data;
                    w_cnt_nxt        = CNT_MAX;
                    w_grant_id_nxt   = w_winner;
                    w_last_grant_nxt = w_winner;
                    w_state_nxt      = DIGIT;
                end
            end
            DIGIT: begin
                if (w_char_hs) begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end else begin
                        w_state_nxt = SEP_EN ? SEPC : IDLE;
                    end
                end
            end
            SEPC: begin
                if (w_char_hs) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_word       <= '0;
            r_cnt        <= '0;
            r_grant_id   <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_word       <= w_word_nxt;
            r_cnt        <= w_cnt_nxt;
            r_grant_id   <= w_grant_id_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

endmodule

// File: tb/tb_hex_print_ctrl.sv
// Bench for hex_print_ctrl: a default instance (4 digits + space) and a 2-digit,
// no-separator instance, both checked every cycle against a character-queue model.
module tb_hex_print_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  r0v = '0;
    logic [1:0]  r1v = '0;
    logic [1:0]  cr  = '0;
    logic [15:0] r0d_a = '0;
    logic [15:0] r1d_a = '0;
    logic [7:0]  r0d_b = '0;
    logic [7:0]  r1d_b = '0;
    wire  [1:0]  r0r, r1r, cv, bsy, gid;
    wire  [7:0]  cd_a, cd_b;

    hex_print_ctrl u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (r0v[0]),
        .req0_data  (r0d_a),
        .req0_ready (r0r[0]),
        .req1_valid (r1v[0]),
        .req1_data  (r1d_a),
        .req1_ready (r1r[0]),
        .char_valid (cv[0]),
        .char_data  (cd_a),
        .char_ready (cr[0]),
        .busy       (bsy[0]),
        .grant_id   (gid[0])
    );

    hex_print_ctrl #(
        .DIGITS (2),
        .SEP_EN (1'b0),
        .SEP    (8'h20)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (r0v[1]),
        .req0_data  (r0d_b),
        .req0_ready (r0r[1]),
        .req1_valid (r1v[1]),
        .req1_data  (r1d_b),
        .req1_ready (r1r[1]),
        .char_valid (cv[1]),
        .char_data  (cd_b),
        .char_ready (cr[1]),
        .busy       (bsy[1]),
        .grant_id   (gid[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h expected=%0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Model: the characters still owed for the current word; empty means idle.
    logic [7:0] mq   [2][$];
    logic [7:0] alog [2][$];
    logic       glog [2][$];
    logic       m_last [2];
    logic       m_gid  [2];
    int         n_r0 [2];
    int         n_r1 [2];
    int         n_busy [2];
    logic       pbsy [2];
    string      hexs = "0123456789ABCDEF";

    int          nd;
    bit          se, idle, win, a_v0, a_v1, a_cr;
    logic [15:0] a_d0, a_d1, w;
    logic [7:0]  a_cd, e_cd;

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_last[k] = 1'b1;
            m_gid[k]  = 1'b0;
            pbsy[k]   = 1'b0;
            n_r0[k] = 0; n_r1[k] = 0; n_busy[k] = 0;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            nd   = (k == 0) ? 4 : 2;
            se   = (k == 0);
            a_v0 = r0v[k];
            a_v1 = r1v[k];
            a_cr = cr[k];
            a_d0 = (k == 0) ? r0d_a : {8'h00, r0d_b};
            a_d1 = (k == 0) ? r1d_a : {8'h00, r1d_b};
            a_cd = (k == 0) ? cd_a : cd_b;
            if (rst) begin
                mq[k].delete();
                m_last[k] = 1'b1;
                m_gid[k]  = 1'b0;
            end
            idle = (mq[k].size() == 0);
            if (a_v0 && a_v1) win = !m_last[k];
            else              win = a_v1;
            e_cd = idle ? 8'h00 : mq[k][0];
            chk("char_valid", k, cv[k], !idle);
            chk("char_data", k, a_cd, e_cd);
            chk("busy", k, bsy[k], !idle);
            chk("grant_id", k, gid[k], m_gid[k]);
            chk("req0_ready", k, r0r[k], idle && a_v0 && !win);
            chk("req1_ready", k, r1r[k], idle && a_v1 && win);
            if (cv[k] && a_cr) alog[k].push_back(a_cd);
            if (bsy[k] && !pbsy[k]) glog[k].push_back(gid[k]);
            pbsy[k] = bsy[k];
            if (r0r[k]) n_r0[k]++;
            if (r1r[k]) n_r1[k]++;
            if (bsy[k]) n_busy[k]++;
            if (!rst) begin
                if (!idle) begin
                    if (a_cr) void'(mq[k].pop_front());
                end else if (a_v0 || a_v1) begin
                    w = win ? a_d1 : a_d0;
                    for (int i = nd - 1; i >= 0; i--) begin
                        mq[k].push_back(hexs[int'((w >> (4 * i)) & 16'hF)]);
                    end
                    if (se) mq[k].push_back(8'h20);
                    m_last[k] = win;
                    m_gid[k]  = win;
                end
            end
        end
    end

    task automatic clear_logs();
        for (int k = 0; k < 2; k++) begin
            alog[k].delete();
            glog[k].delete();
            n_r0[k] = 0; n_r1[k] = 0; n_busy[k] = 0;
        end
    endtask

    task automatic chk_log(input string name, input int k, input string s);
        chk({name, "_len"}, k, alog[k].size(), s.len());
        for (int i = 0; i < s.len(); i++) begin
            chk(name, k, (i < alog[k].size()) ? {24'h0, alog[k][i]} : 32'hFFFF_FFFF,
                {24'h0, s[i]});
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        cr = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_char_valid", 0, cv[0], 1'b0);
        chk("rst_char_data", 0, cd_a, 8'h00);
        chk("rst_busy", 0, bsy[0], 1'b0);
        chk("rst_grant_id", 0, gid[0], 1'b0);
        rst = 1'b0;
        clear_logs();

        // Single word at full rate; data changes after accept must be ignored.
        @(posedge clk); #1 r0v[0] = 1'b1; r0d_a = 16'h1A3F;
        @(posedge clk); #1 r0v[0] = 1'b0; r0d_a = 16'hDEAD;
        repeat (8) @(posedge clk);
        #1;
        chk_log("t1_chars", 0, "1A3F ");
        chk("t1_req0_ready_cycles", 0, n_r0[0], 1);
        chk("t1_busy_cycles", 0, n_busy[0], 5);

        // Backpressure pattern 0,0,1.
        clear_logs();
        r0d_a = 16'h1A3F;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            cr[0]  = (i % 3 == 2);
            r0v[0] = (i == 0);
        end
        cr[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_log("t2_chars", 0, "1A3F ");

        // Tie: round-robin from a fresh reset.
        pulse_reset();
        clear_logs();
        r0d_a = 16'h0000; r1d_a = 16'hFFFF;
        @(posedge clk); #1 r0v[0] = 1'b1; r1v[0] = 1'b1;
        repeat (20) @(posedge clk);
        #1 r0v[0] = 1'b0; r1v[0] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk_log("t3_chars", 0, "0000 FFFF 0000 FFFF ");
        chk("t3_grants", 0, glog[0].size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t3_grant_id", 0, (i < glog[0].size()) ? glog[0][i] : 1'bx, i % 2);
        end

        // Requester 1 alone, three words back to back.
        clear_logs();
        r1d_a = 16'hC0DE;
        @(posedge clk); #1 r1v[0] = 1'b1;
        repeat (14) @(posedge clk);
        #1 r1v[0] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk_log("t4_chars", 0, "C0DE C0DE C0DE ");
        chk("t4_req0_ready_cycles", 0, n_r0[0], 0);
        chk("t4_req1_ready_cycles", 0, n_r1[0], 3);

        // Reset after the second character of a word.
        pulse_reset();
        clear_logs();
        r0d_a = 16'hBEEF;
        @(posedge clk); #1 r0v[0] = 1'b1;
        @(posedge clk); #1 r0v[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t5_char_valid", 0, cv[0], 1'b0);
        chk("t5_busy", 0, bsy[0], 1'b0);
        chk_log("t5_before", 0, "BE");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_logs();
        repeat (6) @(posedge clk);
        #1;
        chk("t5_chars_after", 0, alog[0].size(), 0);

        // Two-digit instance without separator.
        clear_logs();
        r0d_b = 8'hF0;
        @(posedge clk); #1 r0v[1] = 1'b1;
        @(posedge clk); #1 r0v[1] = 1'b0;
        repeat (5) @(posedge clk);
        #1 r0d_b = 8'h9A; r0v[1] = 1'b1;
        @(posedge clk); #1 r0v[1] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk_log("t6_chars", 1, "F09A");
        chk("t6_busy_cycles", 1, n_busy[1], 4);
        chk("t6_req0_ready_cycles", 1, n_r0[1], 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
